// File: rtl/shift_rotate_pipe.sv
// rtl/shift_rotate_pipe.sv - pipelined left/right shift, rotate and arithmetic shift unit
//
// Purpose: one register stage per shift-amount bit; stage k shifts/rotates by
// 2^k when its shamt bit is set. Valid/ready handshakes on both sides, with
// bubble collapsing and a synchronous flush.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   flush              drop every in-flight operation (no accept this cycle)
//   in_valid/in_ready  operation handshake (in_data, in_op, in_shamt, in_tag)
//   out_valid/out_ready result handshake (out_data, out_tag, out_err)
//   busy               any stage holds a valid operation
module shift_rotate_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  // Fixed-distance shift for one stage; illegal ops fall through unchanged.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic [2:0] op,
                                                   input int n);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ROL:  r = (d << n) | (d >> (WIDTH - n));
      OP_SLL:  r = d << n;
      OP_ROR:  r = (d >> n) | (d << (WIDTH - n));
      OP_SRL:  r = d >> n;
      OP_SRA:  r = $unsigned($signed(d) >>> n);
      default: r = d;
    endcase
    return r;
  endfunction

  // Stage registers
  logic [SHW-1:0]   v;
  logic [SHW-1:0]   err_q;
  logic [WIDTH-1:0] d_q   [SHW];
  logic [2:0]       op_q  [SHW];
  logic [SHW-1:0]   sh_q  [SHW];
  logic [TAG_W-1:0] tag_q [SHW];

  // What each stage would capture: its upstream contents, already shifted
  logic [SHW-1:0]   up_v;
  logic [SHW-1:0]   up_err;
  logic [WIDTH-1:0] up_d   [SHW];
  logic [2:0]       up_op  [SHW];
  logic [SHW-1:0]   up_sh  [SHW];
  logic [TAG_W-1:0] up_tag [SHW];
  logic [WIDTH-1:0] nxt_d  [SHW];
  logic [SHW-1:0]   load;

  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_stage
      if (k == 0) begin : g_src
        assign up_v[k]   = in_valid;
        assign up_d[k]   = in_data;
        assign up_op[k]  = in_op;
        assign up_sh[k]  = in_shamt;
        assign up_tag[k] = in_tag;
        assign up_err[k] = (in_op > OP_SRA);
      end else begin : g_src
        assign up_v[k]   = v[k-1];
        assign up_d[k]   = d_q[k-1];
        assign up_op[k]  = op_q[k-1];
        assign up_sh[k]  = sh_q[k-1];
        assign up_tag[k] = tag_q[k-1];
        assign up_err[k] = err_q[k-1];
      end

      // A stage may load when empty or when its occupant moves on this cycle.
      // Since "leaves" = valid && downstream loads, this folds to the form below
      // and gives the combinational ready chain back from out_ready.
      if (k == SHW - 1) begin : g_load
        assign load[k] = !v[k] || out_ready;
      end else begin : g_load
        assign load[k] = !v[k] || load[k+1];
      end

      assign nxt_d[k] = up_sh[k][k] ? stage_shift(up_d[k], up_op[k], 1 << k) : up_d[k];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      err_q <= '0;
      for (int i = 0; i < SHW; i++) begin
        d_q[i]   <= '0;
        op_q[i]  <= '0;
        sh_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < SHW; i++) begin
        if (load[i]) begin
          v[i] <= up_v[i];
          // Payload only moves with a real operation; empty slots keep old data.
          if (up_v[i]) begin
            d_q[i]   <= nxt_d[i];
            op_q[i]  <= up_op[i];
            sh_q[i]  <= up_sh[i];
            tag_q[i] <= up_tag[i];
            err_q[i] <= up_err[i];
          end
        end
      end
    end
  end

  assign in_ready  = load[0] && !flush;
  assign out_valid = v[SHW-1];
  // Stale payload in an empty last stage never reaches the outputs.
  assign out_data  = v[SHW-1] ? d_q[SHW-1]   : '0;
  assign out_tag   = v[SHW-1] ? tag_q[SHW-1] : '0;
  assign out_err   = v[SHW-1] && err_q[SHW-1];
  assign busy      = |v;

endmodule

// File: doc/shift_rotate_pipe.md
Name: shift_rotate_pipe

Overview:
Parametrised, pipelined successor to the single-cycle 16-bit left shift/rotate unit.
- Supports left and right shift/rotate plus arithmetic right shift, at any power-of-two width.
- One pipeline stage per shift-amount bit, with valid/ready handshakes on input and output.
- Sits between the execute-stage operand muxes and writeback, tolerating writeback stalls without dropping operations.

Parameters:
WIDTH, 16, data width in bits; must be a power of two, ≥ 2.
SHW, 4, shift-amount width; must equal log2(WIDTH).
TAG_W, 4, width of an opaque tag carried alongside each operation.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous: invalidate every in-flight operation.
in_valid  input  1  operation offered.
in_ready  output  1  operation accepted this cycle when in_valid && in_ready.
in_data  input  WIDTH  operand.
in_op  input  3  000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA, 101–111 illegal.
in_shamt  input  SHW  shift/rotate amount, 0 .. WIDTH-1.
in_tag  input  TAG_W  tag, returned unmodified with the result.
out_valid  output  1  result present.
out_ready  input  1  consumer takes the result this cycle.
out_data  output  WIDTH  result.
out_tag  output  TAG_W  tag of the result.
out_err  output  1  result came from an illegal op.
busy  output  1  OR of all stage valid bits.

Behaviour:
- Pipeline structure:
  - SHW register stages S0..S(SHW-1).
  - Stage k applies a shift/rotate of 2^k when shamt bit k is 1, otherwise passes the value through.
  - Each stage register holds: valid, data, op, shamt, tag, err.
  - S(SHW-1) drives the out_* ports directly.
- Shift semantics (per stage, shift by n = 2^k):
  - ROL: {d[W-1-n:0], d[W-1:W-n]}.
  - SLL: {d[W-1-n:0], n'b0}.
  - ROR: {d[n-1:0], d[W-1:n]}.
  - SRL: {n'b0, d[W-1:n]}.
  - SRA: {n copies of d[W-1], d[W-1:n]}.
  - Illegal op: data passes unchanged through every stage; err=1 is set at S0.
- Handshake and advancement:
  - Stage k is loaded when it is empty or its contents leave this cycle.
  - S(SHW-1) contents leave when out_ready=1.
  - in_ready = S0 empty OR S0 advancing; this is combinational and chained back from out_ready.
  - Bubbles collapse: an empty stage accepts from its upstream stage even while a downstream stage stalls.
- Latency and throughput:
  - Latency is SHW cycles from acceptance to out_valid when there is no backpressure; WIDTH=16 gives 4 cycles.
  - Throughput is 1 operation per cycle.
  - Capacity is SHW operations in flight.
  - Results emerge in acceptance order.
- Output stability: while out_valid=1 && out_ready=0, out_data, out_tag and out_err hold constant.
- in_valid=0 never loads S0. Data of an empty stage is don't-care but must not affect out_* while out_valid=0.
- shamt=0: result equals in_data for every legal op; latency is unchanged.
- flush:
  - On the clock edge with flush=1, all valid bits clear.
  - Any operation offered that cycle is not accepted; in_ready=0 while flush=1.
  - On the next cycle: out_valid=0, busy=0.
- Reset (asynchronous, any time, including mid-operation or mid-stall):
  - All valid bits, data, tag and err registers clear to 0 immediately.
  - out_valid=0, out_data=0, out_tag=0, out_err=0, busy=0.
  - in_ready=1 once rst deasserts.
  - In-flight operations are discarded and never emerge.
- Simultaneous events:
  - Accept and emit in the same cycle is legal at full occupancy; S0 refills as the pipeline advances.
  - flush has priority over accept and emit. A result with out_valid && out_ready on the flush cycle counts as consumed.
- Illegal in_op: out_err=1, out_data=in_data, tag is preserved, and pipeline flow is normal.

Test Plan:
- WIDTH=16, back-to-back with out_ready=1:
  - ROL 0x8001 by 1 -> 0x0003.
  - SLL 0x8001 by 1 -> 0x0002.
  - ROR 0x1234 by 4 -> 0x4123.
  - SRL 0x8000 by 15 -> 0x0001.
  - SRA 0x8000 by 15 -> 0xFFFF.
  - Expected: outputs appear on consecutive cycles starting 4 cycles after the first accept, with tags 0..4 in order.
- Exhaustive sweep: all 5 legal ops × all 16 shift amounts × random data, compared against a reference model -> zero mismatches; shamt=0 returns data unchanged.
- Backpressure: 6 ops issued back-to-back with out_ready=0 for cycles 3–8:
  - in_ready drops after 4 ops are held.
  - out_data and out_tag are stable while stalled.
  - After release, all 6 results are delivered in order with none lost or duplicated.
- Illegal op: op=110, data 0xBEEF, tag 7 -> after 4 cycles out_err=1, out_data=0xBEEF, out_tag=7; neighbouring legal ops have out_err=0.
- flush with 3 ops in flight and a 4th offered -> next cycle out_valid=0, busy=0; the 4th op is not accepted; a subsequent op completes normally with latency 4.
- rst asserted asynchronously mid-stall, between clock edges -> outputs are 0 immediately; after deassert, in_ready=1 and no pre-reset result emerges.
- Parameter check at WIDTH=32, SHW=5: SRA 0x80000000 by 31 -> 0xFFFFFFFF with latency 5.
